// File: rtl/tile_acc_pkg.sv
`default_nettype none
// ============================================================================
// tile_acc_pkg : shared sizing helpers, FSM states, element functions. rev 1.0
// ============================================================================
package tile_acc_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      CLEAR = 2'd1,
      READ  = 2'd2
   } state_t;

   function automatic int calc_nb(input int matrix_size, input int block_size);
      return matrix_size / block_size;
   endfunction

   function automatic int calc_cw(input int nb);
      return (nb > 1) ? $clog2(nb) : 1;
   endfunction

   function automatic int calc_words(input int matrix_size, input int block_size);
      return matrix_size * (matrix_size / block_size);
   endfunction

   // Treats the low w bits of v as a signed value and extends it to 64 bits.
   function automatic logic [63:0] sign_extend(input logic [63:0] v, input int w);
      logic [63:0] hi_mask;
      hi_mask = ~64'd0 << w;
      return v[6'(w - 1)] ? (v | hi_mask) : (v & ~hi_mask);
   endfunction

   function automatic logic [63:0] saturate(input logic [63:0] v, input int w);
      logic signed [63:0] s;
      logic signed [63:0] hi;
      logic signed [63:0] lo;
      s  = $signed(v);
      hi = (64'sd1 <<< (w - 1)) - 64'sd1;
      lo = -hi - 64'sd1;
      if (s > hi) return hi;
      if (s < lo) return lo;
      return v;
   endfunction

   function automatic logic is_clipped(input logic [63:0] v, input int w);
      logic signed [63:0] s;
      logic signed [63:0] hi;
      logic signed [63:0] lo;
      s  = $signed(v);
      hi = (64'sd1 <<< (w - 1)) - 64'sd1;
      lo = -hi - 64'sd1;
      return (s > hi) || (s < lo);
   endfunction

endpackage
`default_nettype wire

// File: rtl/tile_acc_lane.sv
`default_nettype none
// ============================================================================
// tile_acc_lane : per-element accumulate adder and output reduction (macro TILE_ACC_SAT_EN). rev 1.0
// ============================================================================
module tile_acc_lane
   import tile_acc_pkg::*;
#(
   parameter int DATA_WIDTH  = 16,
   parameter int ACCUM_WIDTH = 24
)(
   input  logic [ACCUM_WIDTH-1:0] acc,
   input  logic [DATA_WIDTH-1:0]  din,
   output logic [ACCUM_WIDTH-1:0] sum,
   output logic [DATA_WIDTH-1:0]  dout
`ifdef TILE_ACC_SAT_EN
   ,
   output logic                   clipped
`endif
);

   // Wraps in two's complement at ACCUM_WIDTH.
   assign sum = acc + ACCUM_WIDTH'(sign_extend(64'(din), DATA_WIDTH));

`ifdef TILE_ACC_SAT_EN
   logic [63:0] acc_wide;

   assign acc_wide = sign_extend(64'(acc), ACCUM_WIDTH);
   assign dout     = DATA_WIDTH'(saturate(acc_wide, DATA_WIDTH));
   assign clipped  = is_clipped(acc_wide, DATA_WIDTH);
`else
   assign dout = acc[DATA_WIDTH-1:0];
`endif

endmodule
`default_nettype wire

// File: rtl/tile_accumulator.sv
`default_nettype none
// ============================================================================
// tile_accumulator : streamed tile accumulate into matrix storage, streamed readout (macro TILE_ACC_SAT_EN). rev 1.0
// ============================================================================
module tile_accumulator
   import tile_acc_pkg::*;
#(
   parameter int  MATRIX_SIZE = 128,
   parameter int  BLOCK_SIZE  = 64,
   parameter int  DATA_WIDTH  = 16,
   parameter int  ACCUM_WIDTH = 24,
   localparam int CW          = calc_cw(calc_nb(MATRIX_SIZE, BLOCK_SIZE))
)(
   input  logic                             clk,
   input  logic                             rst_n,
   input  logic                             start_clear,
   input  logic                             start_read,
   input  logic                             in_valid,
   output logic                             in_ready,
   input  logic [CW-1:0]                    in_row_blk,
   input  logic [CW-1:0]                    in_col_blk,
   input  logic [DATA_WIDTH*BLOCK_SIZE-1:0] in_data,
   output logic                             out_valid,
   input  logic                             out_ready,
   output logic [DATA_WIDTH*BLOCK_SIZE-1:0] out_data,
   output logic                             out_last,
   output logic                             tile_done,
   output logic                             busy
`ifdef TILE_ACC_SAT_EN
   ,
   output logic                             sat_flag
`endif
);

   localparam int NB    = calc_nb(MATRIX_SIZE, BLOCK_SIZE);
   localparam int WORDS = calc_words(MATRIX_SIZE, BLOCK_SIZE);
   localparam int AW    = (WORDS > 1) ? $clog2(WORDS) : 1;
   localparam int RW    = (BLOCK_SIZE > 1) ? $clog2(BLOCK_SIZE) : 1;
   localparam int LW    = BLOCK_SIZE * ACCUM_WIDTH;
   localparam int OW    = BLOCK_SIZE * DATA_WIDTH;

   localparam logic [AW-1:0] LAST_WORD = AW'(WORDS - 1);
   localparam logic [RW-1:0] LAST_ROW  = RW'(BLOCK_SIZE - 1);

   state_t        state;
   state_t        state_nx;

   logic [LW-1:0] mem [WORDS];

   logic          ready_en;
   logic          in_prog;
   logic [RW-1:0] rcnt;
   logic [CW-1:0] tile_row;
   logic [CW-1:0] tile_col;
   logic [CW-1:0] eff_row;
   logic [CW-1:0] eff_col;
   logic [AW-1:0] cptr;
   logic [AW-1:0] rptr;
   logic [AW-1:0] acc_addr;
   logic [AW-1:0] rd_addr;
   logic [LW-1:0] rd_word;
   logic [LW-1:0] wr_word;
   logic [OW-1:0] rd_out;
   logic          accept;
   logic          go_clear;
   logic          go_read;
   logic          out_fire;
   logic          load_word;
`ifdef TILE_ACC_SAT_EN
   logic [BLOCK_SIZE-1:0] clip_vec;
`endif

   assign go_clear  = (state == IDLE) && start_clear;
   assign go_read   = (state == IDLE) && !start_clear && start_read && !in_prog;
   assign in_ready  = ready_en && (state == IDLE) && !start_clear && !start_read;
   assign accept    = in_valid && in_ready;
   assign out_fire  = out_valid && out_ready;
   assign load_word = go_read || ((state == READ) && out_fire && !out_last);
   assign busy      = (state != IDLE) || in_prog;

   // Coordinates come straight from the inputs on the first row, latched afterwards.
   assign eff_row  = (rcnt == '0) ? in_row_blk : tile_row;
   assign eff_col  = (rcnt == '0) ? in_col_blk : tile_col;
   assign acc_addr = AW'((32'(eff_row) * BLOCK_SIZE + 32'(rcnt)) * NB + 32'(eff_col));

   // Single read port shared by readout and read-modify-write.
   assign rd_addr = ((state == READ) || go_read) ? rptr : acc_addr;
   assign rd_word = mem[rd_addr];

   for (genvar j = 0; j < BLOCK_SIZE; j++) begin : g_lane
      tile_acc_lane #(
         .DATA_WIDTH  (DATA_WIDTH),
         .ACCUM_WIDTH (ACCUM_WIDTH)
      ) u_lane (
         .acc     (rd_word[j*ACCUM_WIDTH +: ACCUM_WIDTH]),
         .din     (in_data[j*DATA_WIDTH +: DATA_WIDTH]),
         .sum     (wr_word[j*ACCUM_WIDTH +: ACCUM_WIDTH]),
         .dout    (rd_out[j*DATA_WIDTH +: DATA_WIDTH])
`ifdef TILE_ACC_SAT_EN
         ,
         .clipped (clip_vec[j])
`endif
      );
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      case (state)
         IDLE: begin
            if (go_clear)     state_nx = CLEAR;
            else if (go_read) state_nx = READ;
         end
         CLEAR: begin
            if (cptr == LAST_WORD) state_nx = IDLE;
         end
         READ: begin
            if (out_fire && out_last) state_nx = IDLE;
         end
         default: state_nx = IDLE;
      endcase
   end

   // Storage carries no reset; a clear pass initialises it.
   always_ff @(posedge clk) begin
      if (state == CLEAR)  mem[cptr]     <= '0;
      else if (accept)     mem[acc_addr] <= wr_word;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ready_en  <= 1'b0;
         in_prog   <= 1'b0;
         rcnt      <= '0;
         tile_row  <= '0;
         tile_col  <= '0;
         tile_done <= 1'b0;
         cptr      <= '0;
      end else begin
         ready_en  <= 1'b1;
         tile_done <= 1'b0;
         if (go_clear) begin
            rcnt    <= '0;
            in_prog <= 1'b0;
         end else if (accept) begin
            if (rcnt == '0) begin
               tile_row <= in_row_blk;
               tile_col <= in_col_blk;
            end
            if (rcnt == LAST_ROW) begin
               rcnt      <= '0;
               in_prog   <= 1'b0;
               tile_done <= 1'b1;
            end else begin
               rcnt    <= rcnt + RW'(1);
               in_prog <= 1'b1;
            end
         end
         if ((state == CLEAR) && (cptr != LAST_WORD)) cptr <= cptr + AW'(1);
         else                                         cptr <= '0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid <= 1'b0;
         out_last  <= 1'b0;
         out_data  <= '0;
         rptr      <= '0;
`ifdef TILE_ACC_SAT_EN
         sat_flag  <= 1'b0;
`endif
      end else begin
         if (load_word) begin
            out_data  <= rd_out;
            out_valid <= 1'b1;
            out_last  <= (rptr == LAST_WORD);
            rptr      <= rptr + AW'(1);
         end else if ((state == READ) && out_fire) begin
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            rptr      <= '0;
         end
`ifdef TILE_ACC_SAT_EN
         if (go_clear)                    sat_flag <= 1'b0;
         else if (load_word && |clip_vec) sat_flag <= 1'b1;
`endif
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_tile_accumulator.sv
`default_nettype none
// ============================================================================
// tb_tile_accumulator : scoreboard bench, 8x8 matrix of 4x4 tiles. rev 1.0
// ============================================================================
module tb_tile_accumulator;

   localparam int M     = 8;
   localparam int B     = 4;
   localparam int DW    = 16;
   localparam int ACW   = 24;
   localparam int NB    = M / B;
   localparam int WORDS = M * NB;

   typedef int tile_t [B][B];
   typedef struct {
      logic [DW*B-1:0] data;
      logic            last;
   } exp_t;

   logic            clk = 1'b0;
   logic            rst_n = 1'b0;
   logic            start_clear = 1'b0;
   logic            start_read = 1'b0;
   logic            in_valid = 1'b0;
   logic            in_ready;
   logic            in_row_blk = 1'b0;
   logic            in_col_blk = 1'b0;
   logic [DW*B-1:0] in_data = '0;
   logic            out_valid;
   logic            out_ready = 1'b1;
   logic [DW*B-1:0] out_data;
   logic            out_last;
   logic            tile_done;
   logic            busy;
`ifdef TILE_ACC_SAT_EN
   logic            sat_flag;
   bit              sat_exp = 1'b0;
`endif

   exp_t   q[$];
   longint model [M][M];
   int     n_cmp  = 0;
   int     n_fail = 0;
   bit     rand_stall = 1'b0;

   tile_accumulator #(
      .MATRIX_SIZE (M),
      .BLOCK_SIZE  (B),
      .DATA_WIDTH  (DW),
      .ACCUM_WIDTH (ACW)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .start_clear (start_clear),
      .start_read  (start_read),
      .in_valid    (in_valid),
      .in_ready    (in_ready),
      .in_row_blk  (in_row_blk),
      .in_col_blk  (in_col_blk),
      .in_data     (in_data),
      .out_valid   (out_valid),
      .out_ready   (out_ready),
      .out_data    (out_data),
      .out_last    (out_last),
      .tile_done   (tile_done),
      .busy        (busy)
`ifdef TILE_ACC_SAT_EN
      ,
      .sat_flag    (sat_flag)
`endif
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Accumulator value as stored (24-bit wrap), then reduced to the output width.
   function automatic longint wrap_acc(input longint a);
      longint w;
      w = a & 16777215;
      if (w >= 8388608) w = w - 16777216;
      return w;
   endfunction

   function automatic logic [DW-1:0] exp_elem(input longint a);
      longint w;
      w = wrap_acc(a);
`ifdef TILE_ACC_SAT_EN
      if (w > 32767)  w = 32767;
      if (w < -32768) w = -32768;
`endif
      return DW'(w);
   endfunction

   function automatic logic [DW*B-1:0] exp_word(input int w);
      logic [DW*B-1:0] v;
      int r;
      int cb;
      r  = w / NB;
      cb = w % NB;
      for (int j = 0; j < B; j++) v[j*DW +: DW] = exp_elem(model[r][cb*B + j]);
      return v;
   endfunction

   // Monitor: every presented word is compared against the queue head.
   always @(negedge clk) begin
      if (rst_n && out_valid) begin
         if (q.size() == 0) begin
            check("extra_word", {63'd0, out_valid}, 64'd0);
         end else begin
            check("out_data", out_data, q[0].data);
            check("out_last", {63'd0, out_last}, {63'd0, q[0].last});
            if (out_ready) void'(q.pop_front());
         end
      end
   end

   initial begin
      forever begin
         @(posedge clk);
         #1;
         out_ready = rand_stall ? 1'($urandom_range(0, 1)) : 1'b1;
      end
   end

   task automatic wait_accept();
      int t;
      t = 0;
      forever begin
         @(negedge clk);
         if (in_ready) break;
         t++;
         if (t > 200) begin
            check("accept_timeout", 64'd0, 64'd1);
            break;
         end
      end
      @(posedge clk);
      #1;
   endtask

   // Sends rows first..last of a tile; non-first rows carry random coordinates.
   task automatic send_rows(input int rb, input int cb, input tile_t d, input int first, input int last);
      for (int i = first; i <= last; i++) begin
         in_valid   = 1'b1;
         in_row_blk = (i == 0) ? 1'(rb) : 1'($urandom_range(0, 1));
         in_col_blk = (i == 0) ? 1'(cb) : 1'($urandom_range(0, 1));
         for (int j = 0; j < B; j++) in_data[j*DW +: DW] = DW'(d[i][j]);
         wait_accept();
         for (int j = 0; j < B; j++) model[rb*B + i][cb*B + j] += longint'(d[i][j]);
      end
      in_valid = 1'b0;
      if (last == B - 1) begin
         @(negedge clk);
         check("tile_done", {63'd0, tile_done}, 64'd1);
         @(posedge clk);
         #1;
      end
   endtask

   task automatic send_tile(input int rb, input int cb, input tile_t d);
      send_rows(rb, cb, d, 0, B - 1);
   endtask

   task automatic do_clear();
      int n;
      n = 0;
      start_clear = 1'b1;
      #1;
      check("ready_during_clear", {63'd0, in_ready}, 64'd0);
      @(posedge clk);
      #1;
      start_clear = 1'b0;
      in_valid    = 1'b0;
      while (n < 100) begin
         @(negedge clk);
         if (!busy) break;
         n++;
      end
      check("clear_busy_cycles", 64'(n), 64'(WORDS));
      check("ready_after_clear", {63'd0, in_ready}, 64'd1);
      for (int r = 0; r < M; r++)
         for (int c = 0; c < M; c++) model[r][c] = 0;
`ifdef TILE_ACC_SAT_EN
      sat_exp = 1'b0;
`endif
      @(posedge clk);
      #1;
   endtask

   task automatic push_expected();
      exp_t e;
      for (int w = 0; w < WORDS; w++) begin
         e.data = exp_word(w);
         e.last = (w == WORDS - 1);
         q.push_back(e);
      end
`ifdef TILE_ACC_SAT_EN
      for (int r = 0; r < M; r++)
         for (int c = 0; c < M; c++)
            if (wrap_acc(model[r][c]) > 32767 || wrap_acc(model[r][c]) < -32768) sat_exp = 1'b1;
`endif
   endtask

   task automatic do_read(input bit stall);
      int t;
      t = 0;
      push_expected();
      rand_stall = stall;
      start_read = 1'b1;
      @(posedge clk);
      #1;
      start_read = 1'b0;
      @(negedge clk);
      check("valid_after_start", {63'd0, out_valid}, 64'd1);
      while (q.size() > 0 && t < 2000) begin
         @(negedge clk);
         t++;
      end
      if (q.size() != 0) begin
         check("read_words_left", 64'(q.size()), 64'd0);
         q.delete();
      end
      @(negedge clk);
      check("idle_after_read", {63'd0, out_valid}, 64'd0);
      rand_stall = 1'b0;
`ifdef TILE_ACC_SAT_EN
      check("sat_flag", {63'd0, sat_flag}, {63'd0, sat_exp});
`endif
      @(posedge clk);
      #1;
   endtask

   function automatic tile_t const_tile(input int v);
      tile_t d;
      for (int i = 0; i < B; i++)
         for (int j = 0; j < B; j++) d[i][j] = v;
      return d;
   endfunction

   function automatic tile_t rand_tile(input int lo, input int hi);
      tile_t d;
      for (int i = 0; i < B; i++)
         for (int j = 0; j < B; j++) d[i][j] = lo + int'($urandom_range(0, hi - lo));
      return d;
   endfunction

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      tile_t d;
      for (int r = 0; r < M; r++)
         for (int c = 0; c < M; c++) model[r][c] = 0;

      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rst_in_ready",  {63'd0, in_ready},  64'd0);
      check("rst_out_valid", {63'd0, out_valid}, 64'd0);
      check("rst_out_last",  {63'd0, out_last},  64'd0);
      check("rst_tile_done", {63'd0, tile_done}, 64'd0);
      check("rst_busy",      {63'd0, busy},      64'd0);
      check("rst_out_data",  out_data,           64'd0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      check("ready_after_reset", {63'd0, in_ready}, 64'd1);

      // Zeroed matrix readout.
      do_clear();
      do_read(1'b0);

      // Same tile twice: rows 4..7, cols 0..3 read 6.
      send_tile(1, 0, const_tile(3));
      send_tile(1, 0, const_tile(3));
      do_read(1'b0);

      // Mixed-sign accumulation, readout with stalls.
      do_clear();
      send_tile(0, 1, const_tile(7));
      d = const_tile(-5);
      d[1][2] = 100;
      d[3][0] = -32768;
      send_tile(0, 1, d);
      send_tile(1, 1, rand_tile(-300, 300));
      do_read(1'b1);

      // Beyond the output range: 40000 and -40000.
      do_clear();
      d = rand_tile(-9, 9);
      d[0][0] = 20000;
      d[2][3] = -20000;
      send_tile(0, 0, d);
      send_tile(0, 0, d);
      do_read(1'b0);

      // start_read during a partial tile is ignored.
      do_clear();
      d = rand_tile(-1000, 1000);
      send_rows(1, 1, d, 0, 1);
      start_read = 1'b1;
      @(posedge clk);
      #1;
      start_read = 1'b0;
      @(negedge clk);
      check("read_ignored_valid", {63'd0, out_valid}, 64'd0);
      check("partial_busy",       {63'd0, busy},      64'd1);
      @(posedge clk);
      #1;
      send_rows(1, 1, d, 2, 3);
      do_read(1'b1);

      // start_clear beats a simultaneous input beat.
      in_valid = 1'b1;
      in_data  = {4{16'h0055}};
      do_clear();
      send_tile(1, 0, const_tile(2));
      do_read(1'b0);

      // Randomised rounds.
      for (int round = 0; round < 3; round++) begin
         do_clear();
         for (int k = 0; k < 5; k++)
            send_tile(int'($urandom_range(0, 1)), int'($urandom_range(0, 1)), rand_tile(-32768, 32767));
         do_read(1'b1);
      end

      // Reset mid-readout.
      push_expected();
      rand_stall = 1'b1;
      start_read = 1'b1;
      @(posedge clk);
      #1;
      start_read = 1'b0;
      repeat (5) @(negedge clk);
      rst_n = 1'b0;
      #1;
      check("rst_mid_out_valid", {63'd0, out_valid}, 64'd0);
      check("rst_mid_in_ready",  {63'd0, in_ready},  64'd0);
      check("rst_mid_busy",      {63'd0, busy},      64'd0);
      q.delete();
      rand_stall = 1'b0;
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      do_clear();
      do_read(1'b0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/tile_accumulator.md
# tile_accumulator

Parametrised tile accumulator that sums streamed partial-product tiles of BLOCK_SIZE x BLOCK_SIZE into an output matrix of MATRIX_SIZE x MATRIX_SIZE. It accepts one tile row per beat over a valid/ready handshake, updates its storage with a read-modify-write, and streams the finished matrix out over a second valid/ready port. It sits between the block MAC array and the writeback/normalisation stage. It replaces the earlier fixed 128/64 level-triggered accumulator, whose whole matrix was exposed as one flat bus.

## Interface
- MATRIX_SIZE, 128, output matrix dimension; must be a multiple of BLOCK_SIZE
- BLOCK_SIZE, 64, tile dimension; elements per beat
- DATA_WIDTH, 16, signed element width for input and output
- ACCUM_WIDTH, 24, signed storage width; must be at least DATA_WIDTH
- Derived: NB = MATRIX_SIZE/BLOCK_SIZE; CW = max(1, clog2(NB)); WORDS = MATRIX_SIZE*NB
- Clock and reset: one clock; reset is asynchronous and active-low.
- clk  in  1  single clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- start_clear  in  1  single-cycle pulse that zeroes all storage
- start_read  in  1  single-cycle pulse that starts the matrix readout
- in_valid  in  1  input beat valid
- in_ready  out  1  input beat accepted when high together with in_valid
- in_row_blk  in  CW  tile row-block index; sampled on the first beat of a tile
- in_col_blk  in  CW  tile column-block index; sampled on the first beat of a tile
- in_data  in  DATA_WIDTH*BLOCK_SIZE  one tile row; element j is at bits [(j+1)*DATA_WIDTH-1 : j*DATA_WIDTH]
- out_valid  out  1  output word valid
- out_ready  in  1  downstream accepts the output word
- out_data  out  DATA_WIDTH*BLOCK_SIZE  one matrix row segment, using the same element packing as in_data
- out_last  out  1  high with the final word of a readout
- tile_done  out  1  one-cycle pulse after the last row of a tile is accepted
- busy  out  1  high in CLEAR or READ, or while a tile is partially received

## Operation
- Storage: WORDS words, each BLOCK_SIZE*ACCUM_WIDTH bits. Word index = row*NB + col_blk, where row is the global matrix row.
- FSM states: IDLE, CLEAR, READ.
- IDLE -> CLEAR on start_clear. CLEAR writes zero to one word per cycle for WORDS cycles, then returns to IDLE.
- IDLE -> READ on start_read, but only when no tile is in progress. READ -> IDLE after the beat carrying out_last is accepted.
- in_ready is high only in IDLE and only when start_clear and start_read are both low.
- Accumulation, on each accepted beat:
  - Target word is (tile_row_blk*BLOCK_SIZE + rcnt)*NB + tile_col_blk.
  - Each element is sign-extended to ACCUM_WIDTH and added to the stored value, wrapping in two's complement.
- rcnt counts 0..BLOCK_SIZE-1. It is reset by reset and by start_clear.
- The tile coordinates are latched when a beat is accepted with rcnt==0. The coordinate inputs are ignored on all other beats.
- When rcnt wraps from BLOCK_SIZE-1 to 0, tile_done pulses and the tile-in-progress flag drops.
- Readout streams words 0..WORDS-1 in row-major order. Each element is reduced from ACCUM_WIDTH to DATA_WIDTH; see Configuration.
- Priority when events coincide: start_clear beats start_read, which beats an input beat.
- start_clear or start_read outside IDLE is ignored.
- start_read during a partial tile is ignored.
- A hit-count register per tile is not provided. Any tile may be accumulated any number of times between clears.

## Timing
- Reset values:
  - in_ready=0, out_valid=0, out_last=0, tile_done=0, busy=0, out_data=0
  - rcnt=0; FSM in IDLE
  - Storage is not reset; a start_clear is required before first use.
- in_ready rises on the first cycle after rst_n deasserts.
- Accumulate latency: a beat accepted at cycle t updates storage at edge t+1. Back-to-back beats at one per cycle are supported.
- tile_done is asserted in the cycle after the last beat of a tile is accepted.
- Clear duration: busy is high for exactly WORDS cycles starting the cycle after start_clear. in_ready returns in the following cycle.
- Readout:
  - out_valid rises one cycle after start_read.
  - out_data, out_valid and out_last are registered and held stable while out_ready is low.
  - Sustained throughput is one word per cycle while out_ready is high.
- rst_n assertion mid-operation aborts everything asynchronously. The FSM returns to IDLE, rcnt goes to 0, and all outputs go to their reset values.

## Configuration
- TILE_ACC_SAT_EN defined:
  - Each output element saturates to [-2^(DATA_WIDTH-1), 2^(DATA_WIDTH-1)-1].
  - A sticky output sat_flag, 1 bit, reset 0, is added. It is set when any read element is clipped and cleared by start_clear.
- TILE_ACC_SAT_EN undefined: the output is the low DATA_WIDTH bits of each accumulator (truncation), and the sat_flag port does not exist.

## Structure
- Shared package tile_acc_pkg holds:
  - the NB, CW and WORDS derivation functions
  - the state enum (IDLE, CLEAR, READ)
  - the sign-extend and saturate functions
- One sub-module, tile_acc_lane: a per-element adder plus saturation/truncation slice. It is instantiated BLOCK_SIZE times via generate, shared by the accumulate and readout paths.

## Test plan
- Reset, then clear, then read with MATRIX_SIZE=8, BLOCK_SIZE=4 -> 16 words are read, all zero; out_last on word 15; busy is high for 16 cycles during the clear.
- Tile (1,0) with every element 3, sent twice -> rows 4..7, columns 0..3 read 6; every other element reads 0; tile_done pulses twice.
- A DATA_WIDTH=16 element of -5 added to 7 -> reads 2. Sign extension is correct for mixed-sign tiles.
- Accumulated 40000 with ACCUM_WIDTH=24 -> reads 32767 with TILE_ACC_SAT_EN, sat_flag=1; reads 40000 mod 2^16 as signed (-25536) without it.
- Random out_ready stalls during readout -> out_data is stable while stalled; the word order and count are unchanged.
- start_read after 2 of 4 rows of a tile -> ignored. start_clear together with in_valid -> the clear wins and the beat is not accepted. rst_n pulsed mid-readout -> out_valid=0 in the same cycle.
